bubble_control_fsm: RTL
=======================

// Module: bubble_control_fsm
// PURPOSE
//  Multi-cycle sequencer for the BUBBLE datapath. Fetches 32-bit instructions, reads the
//  register file, presents decoded fields to the combinational ALU (opcode/funct/shamt/s1/s2/
//  pc/const/jumpAddress), then writes back dest or updates the PC from pcNew. It sits between
//  instruction memory, register file and ALU, and is the only PC owner.
// PARAMETERS
//  RESET_PC     16'd0   PC loaded at reset; first fetch address after start
//  HALT_OPCODE  6'd63   opcode that stops the sequencer
// PORTS
//  clk          in   1   single clock, all state updates on rising edge
//  rst          in   1   synchronous, active-high reset
//  start        in   1   IDLE->FETCH when high; ignored in every other state
//  imem_req     out  1   instruction fetch request
//  imem_addr    out  16  word address of fetch (= PC)
//  imem_ready   in   1   fetch complete; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  rf_raddr1/2  out  5   register read addresses (rs = IR[25:21], rt = IR[20:16])
//  rf_rdata1/2  in   32  combinational register read data
//  rf_we        out  1   one-cycle write-enable pulse
//  rf_waddr     out  5   write address
//  rf_wdata     out  32  write data (ALU dest)
//  alu_opcode   out  6   IR[31:26]
//  alu_funct    out  5   IR[4:0]
//  alu_shamt    out  5   IR[10:6]
//  alu_s1/s2    out  32  operands (rs value, rt value)
//  alu_pc       out  16  PC of current instruction
//  alu_const    out  16  IR[15:0]
//  alu_jump     out  26  IR[25:0]
//  alu_dest     in   32  ALU result
//  alu_pcnew    in   16  ALU next-PC (branch/jump)
//  busy         out  1   high in FETCH/DECODE/EXECUTE/WRITEBACK
//  halted       out  1   high in HALT
// BEHAVIOUR
//  - Reset: state IDLE, PC=RESET_PC, IR=0; all outputs 0 except imem_addr=RESET_PC.
//  - States: IDLE -> FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH; HALT is terminal.
//  - FETCH: imem_req=1, imem_addr=PC held stable until imem_ready sampled high; then IR<=imem_rdata,
//    imem_req drops, ->DECODE. No timeout; waits indefinitely.
//  - DECODE: rf_raddr1/2 from IR; rf_rdata1/2 registered into alu_s1/s2, IR fields into alu_*
//    outputs; ->EXECUTE, or ->HALT if opcode==HALT_OPCODE.
//  - EXECUTE: alu_* outputs stable; alu_dest and alu_pcnew registered; ->WRITEBACK.
//  - WRITEBACK: opcode 0 (R-type) writes rd=IR[15:11]; opcodes 1-6 (I-type) write rt; rf_we=1 this
//    cycle only, rf_wdata=registered dest. Write to r0 suppressed (rf_we stays 0).
//    Opcodes 7-13 (branch/jump): no write, PC<=registered alu_pcnew. All others: PC<=PC+1.
//    Opcodes 14-62: NOP (no write, PC+1). ->FETCH.
//  - PC arithmetic 16-bit unsigned, wraps 16'hFFFF -> 16'h0000.
//  - Min latency 4 cycles/instruction (imem_ready in first FETCH cycle); each imem wait cycle adds 1.
//  - HALT: busy=0, halted=1, imem_req=0, rf_we=0; exits only via rst.
//  - rst in any state (incl. mid-FETCH or WRITEBACK) wins: next cycle IDLE, no rf_we, PC=RESET_PC.
// TESTING
//  - r1=123,r2=23, IR={6'd0,5'd1,5'd2,5'd3,5'd0,6'd0}, imem_ready immediate -> rf_we pulse 4th cycle
//    after FETCH entry, rf_waddr=3, rf_wdata=146; next imem_addr=1.
//  - imem_ready held low 3 cycles -> imem_req=1, imem_addr unchanged throughout; writeback 3 cycles later.
//  - PC=3, opcode 7, s1=s2=23, const=1000, ALU stub pcnew=1004 -> no rf_we; next imem_addr=1004.
//  - opcode 13, jump=512, stub pcnew=512 -> next fetch at 512; R-type with rd=0 -> rf_we never asserted.
//  - PC=16'hFFFF, opcode 1 -> next imem_addr=0; opcode 63 -> halted=1, busy=0, start pulses ignored.
//  - rst asserted during EXECUTE -> next cycle IDLE, busy=0, rf_we=0, imem_addr=RESET_PC.

Source files
------------

// File: rtl/bubble_control_fsm.sv
// Purpose : multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer and sole PC owner for the BUBBLE datapath.
// Latency : 4 cycles per instruction when imem_ready is high in the first FETCH cycle; +1 per imem wait cycle.
// Backpr. : FETCH holds imem_req/imem_addr until imem_ready is sampled high; no other stage stalls.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start               launches the first fetch from IDLE; ignored elsewhere
//   imem_req/addr       fetch request and word address (= PC)
//   imem_ready/rdata    fetch completion and instruction word
//   rf_raddr1/2         rs / rt read addresses, driven from IR
//   rf_rdata1/2         combinational register read data
//   rf_we/waddr/wdata   one-cycle write-back pulse, address and data
//   alu_*  (out)        decoded fields and operands for the combinational ALU
//   alu_dest/pcnew (in) ALU result and branch/jump target
//   busy, halted        sequencer status
module bubble_control_fsm #(
  parameter logic [15:0] RESET_PC    = 16'd0,
  parameter logic [5:0]  HALT_OPCODE = 6'd63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [5:0]  alu_opcode,
  output logic [4:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [31:0] alu_s1,
  output logic [31:0] alu_s2,
  output logic [15:0] alu_pc,
  output logic [15:0] alu_const,
  output logic [25:0] alu_jump,
  input  logic [31:0] alu_dest,
  input  logic [15:0] alu_pcnew,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [31:0] r_ir;
  logic        r_imem_req;
  logic        r_busy;
  logic        r_halted;
  logic        r_rf_we;
  logic [4:0]  r_rf_waddr;
  logic [31:0] r_dest;
  logic [15:0] r_pcnew;
  logic [5:0]  r_alu_opcode;
  logic [4:0]  r_alu_funct;
  logic [4:0]  r_alu_shamt;
  logic [31:0] r_alu_s1;
  logic [31:0] r_alu_s2;
  logic [15:0] r_alu_pc;
  logic [15:0] r_alu_const;
  logic [25:0] r_alu_jump;

  // Instruction class of the instruction currently past DECODE.
  logic        w_is_rtype;
  logic        w_is_itype;
  logic        w_is_branch;
  logic [4:0]  w_wr_addr;
  logic        w_wr_en;

  assign w_is_rtype  = (r_alu_opcode == 6'd0);
  assign w_is_itype  = (r_alu_opcode >= 6'd1) && (r_alu_opcode <= 6'd6);
  assign w_is_branch = (r_alu_opcode >= 6'd7) && (r_alu_opcode <= 6'd13);
  // R-type targets rd, I-type targets rt; r0 is hard-wired so its write is dropped.
  assign w_wr_addr   = w_is_rtype ? r_ir[15:11] : r_ir[20:16];
  assign w_wr_en     = (w_is_rtype || w_is_itype) && (w_wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_imem_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_dest       <= '0;
      r_pcnew      <= '0;
      r_alu_opcode <= '0;
      r_alu_funct  <= '0;
      r_alu_shamt  <= '0;
      r_alu_s1     <= '0;
      r_alu_s2     <= '0;
      r_alu_pc     <= '0;
      r_alu_const  <= '0;
      r_alu_jump   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_FETCH;
            r_imem_req <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready) begin
            r_ir       <= imem_rdata;
            r_imem_req <= 1'b0;
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          // rf_raddr1/2 come straight from IR, so read data is valid this cycle.
          r_alu_opcode <= r_ir[31:26];
          r_alu_funct  <= r_ir[4:0];
          r_alu_shamt  <= r_ir[10:6];
          r_alu_const  <= r_ir[15:0];
          r_alu_jump   <= r_ir[25:0];
          r_alu_s1     <= rf_rdata1;
          r_alu_s2     <= rf_rdata2;
          r_alu_pc     <= r_pc;
          if (r_ir[31:26] == HALT_OPCODE) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_dest     <= alu_dest;
          r_pcnew    <= alu_pcnew;
          r_rf_we    <= w_wr_en;
          r_rf_waddr <= w_wr_addr;
          r_state    <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          r_rf_we    <= 1'b0;
          r_pc       <= w_is_branch ? r_pcnew : r_pc + 16'd1;
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          // Terminal: only rst leaves this state.
          r_state <= S_HALT;
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
          r_busy     <= 1'b0;
          r_rf_we    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign rf_raddr1  = r_ir[25:21];
  assign rf_raddr2  = r_ir[20:16];
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_dest;
  assign alu_opcode = r_alu_opcode;
  assign alu_funct  = r_alu_funct;
  assign alu_shamt  = r_alu_shamt;
  assign alu_s1     = r_alu_s1;
  assign alu_s2     = r_alu_s2;
  assign alu_pc     = r_alu_pc;
  assign alu_const  = r_alu_const;
  assign alu_jump   = r_alu_jump;
  assign busy       = r_busy;
  assign halted     = r_halted;

endmodule
